// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkg
//  Description : Shared definitions for the buffered valid/ready slave:
//                pointer layout, address-width helper and pointer increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Widest address field needed (DEPTH up to 256).
    localparam int c_PTR_ADDR_MAX = 8;

    // FIFO pointer: address plus a wrap bit that toggles on every pass.
    typedef struct packed {
        logic                      wrap;
        logic [c_PTR_ADDR_MAX-1:0] addr;
    } ptr_t;

    // Ceiling log2 for address sizing; valid for 1..2^31.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Advance a pointer, wrapping depth-1 -> 0 and toggling the wrap bit.
    function automatic ptr_t ptr_inc(input ptr_t p, input int depth);
        ptr_t n;
        n = p;
        if (int'(p.addr) == depth - 1) begin
            n.addr = '0;
            n.wrap = ~p.wrap;
        end else begin
            n.addr = p.addr + 1'b1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : DATA_W x DEPTH storage, one synchronous write port and one
//                asynchronous read port. Contents are never cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: store the word on a push edge.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/axis_slave_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_slave_fifo
//  Description : valid/ready slave feeding a DEPTH-entry first-word
//                fall-through FIFO re-issued on a valid/ready master port.
//                Reports occupancy, almost-full and a sticky upstream
//                protocol-violation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_slave_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [clog2_f(DEPTH):0] count,
    output logic                  almost_full,
    output logic                  proto_err
);

    localparam int                c_ADDR_W = clog2_f(DEPTH);
    localparam logic [c_ADDR_W:0] c_AFULL  = AFULL_LVL[c_ADDR_W:0];

    ptr_t              r_wr_ptr;
    ptr_t              r_rd_ptr;
    logic [c_ADDR_W:0] r_count;
    logic              r_valid_q;
    logic              r_ready_q;
    logic [DATA_W-1:0] r_data_q;
    logic              r_proto_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rdata;

    // Flags depend only on registered pointers, so s_ready has no path from m_ready.
    assign w_full  = (r_wr_ptr.addr == r_rd_ptr.addr) && (r_wr_ptr.wrap != r_rd_ptr.wrap);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = s_valid & ~w_full;
    assign w_pop   = m_ready & ~w_empty;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push & ~rst),
        .i_waddr (r_wr_ptr.addr[c_ADDR_W-1:0]),
        .i_wdata (s_data),
        .i_raddr (r_rd_ptr.addr[c_ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Pointer and occupancy update; reset overrides any push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr, DEPTH);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr, DEPTH);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag: a stalled word (valid & ~ready) must be held unchanged next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            r_data_q    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_valid_q <= s_valid;
            r_ready_q <= s_ready;
            r_data_q  <= s_data;
            if (r_valid_q && !r_ready_q && (!s_valid || (s_data != r_data_q)))
                r_proto_err <= 1'b1;
        end
    end

    assign s_ready     = ~w_full;
    assign m_valid     = ~w_empty;
    assign m_data      = m_valid ? w_rdata : '0;
    assign count       = r_count;
    assign almost_full = (r_count >= c_AFULL);
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_slave_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_slave_fifo
//  Description : Directed, table-driven bench for axis_slave_fifo
//                (DEPTH=4, AFULL_LVL=3, DATA_W=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_slave_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  count;
    logic        almost_full;
    logic        proto_err;

    int checks;
    int errors;

    axis_slave_fifo #(
        .DATA_W    (32),
        .DEPTH     (4),
        .AFULL_LVL (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .count       (count),
        .almost_full (almost_full),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        s_valid;
        logic [31:0] s_data;
        logic        m_ready;
        logic        e_s_ready;
        logic        e_m_valid;
        logic [31:0] e_m_data;
        logic [2:0]  e_count;
        logic        e_afull;
        logic        e_perr;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock one edge, sample #1 after it.
    task automatic step(input logic r, input logic sv, input logic [31:0] sd, input logic mr);
        rst     = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic sr, input logic mv, input logic [31:0] md,
                           input logic [2:0] cnt, input logic af, input logic pe);
        chk({tag, ".s_ready"},     {31'd0, s_ready},     {31'd0, sr});
        chk({tag, ".m_valid"},     {31'd0, m_valid},     {31'd0, mv});
        chk({tag, ".m_data"},      m_data,               md);
        chk({tag, ".count"},       {29'd0, count},       {29'd0, cnt});
        chk({tag, ".almost_full"}, {31'd0, almost_full}, {31'd0, af});
        chk({tag, ".proto_err"},   {31'd0, proto_err},   {31'd0, pe});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        //            rst sv  data          mr  sr  mv  m_data        cnt af  pe
        vecs[0]  = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        3'd0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        3'd0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        3'd0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,32'hA5A5_0001,1'b0,1'b1,1'b1,32'hA5A5_0001,3'd1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'hA5A5_0001,3'd1,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0,        3'd0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,32'd1,        1'b0,1'b1,1'b1,32'd1,        3'd1,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b1,32'd2,        1'b0,1'b1,1'b1,32'd1,        3'd2,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,32'd3,        1'b0,1'b1,1'b1,32'd1,        3'd3,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b1,32'd4,        1'b0,1'b0,1'b1,32'd1,        3'd4,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b1,32'd5,        1'b0,1'b0,1'b1,32'd1,        3'd4,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,32'd5,        1'b1,1'b1,1'b1,32'd2,        3'd3,1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,32'd5,        1'b0,1'b0,1'b1,32'd2,        3'd4,1'b1,1'b0};
        vecs[13] = '{1'b0,1'b0,32'd0,        1'b1,1'b1,1'b1,32'd3,        3'd3,1'b1,1'b0};
        vecs[14] = '{1'b0,1'b0,32'd0,        1'b1,1'b1,1'b1,32'd4,        3'd2,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b0,32'd0,        1'b1,1'b1,1'b1,32'd5,        3'd1,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b0,32'd0,        1'b1,1'b1,1'b0,32'd0,        3'd0,1'b0,1'b0};

        // Reset, single word, fill/stall/drain.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].s_valid, vecs[i].s_data, vecs[i].m_ready);
            chk_all($sformatf("vec%0d", i), vecs[i].e_s_ready, vecs[i].e_m_valid,
                    vecs[i].e_m_data, vecs[i].e_count, vecs[i].e_afull, vecs[i].e_perr);
        end

        // Continuous stream with pointer wrap: one word per cycle, count steady at 1.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, i, 1'b1);
            chk($sformatf("stream%0d.m_data", i), m_data, i);
            chk($sformatf("stream%0d.count", i), {29'd0, count}, 32'd1);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk_all("stream_end", 1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        // Valid withdrawn while stalled.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 32'h100 + i, 1'b0);
        step(1'b0, 1'b1, 32'h9, 1'b0);
        chk("perr_hold", {31'd0, proto_err}, 32'd0);
        step(1'b0, 1'b0, 32'h9, 1'b0);
        chk_all("perr_drop", 1'b0, 1'b1, 32'h101, 3'd4, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("perr_sticky", {31'd0, proto_err}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_all("perr_rst", 1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        // Data changed while stalled.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 32'h200 + i, 1'b0);
        step(1'b0, 1'b1, 32'h9, 1'b0);
        chk("perr2_hold", {31'd0, proto_err}, 32'd0);
        step(1'b0, 1'b1, 32'hA, 1'b0);
        chk("perr2_data", {31'd0, proto_err}, 32'd1);
        chk("perr2_head", m_data, 32'h201);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("perr2_rst", {31'd0, proto_err}, 32'd0);

        // Reset mid-operation discards buffered words.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 32'h300 + i, 1'b0);
        chk("mid_count", {29'd0, count}, 32'd3);
        step(1'b1, 1'b1, 32'h77, 1'b1);
        chk_all("mid_rst", 1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hBEEF, 1'b0);
        chk_all("mid_first", 1'b1, 1'b1, 32'hBEEF, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("mid_drain", 1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_slave_fifo.md
Name: axis_slave_fifo

Overview:
- Parametrised successor to the single-word valid/ready receive slave.
- Accepts words on a valid/ready slave port and buffers them in a DEPTH-entry FIFO.
- Re-issues words on a valid/ready master port, so downstream back-pressure no longer drops data.
- Adds occupancy and almost-full reporting, plus a sticky protocol-violation flag.
- Sits between a bus master and a consumer in the handshake fabric.

Parameters:
- DATA_W, 32, width of s_data/m_data in bits (1..256).
- DEPTH, 4, FIFO entries; power of two, 2..256.
- AFULL_LVL, 3, almost_full asserts when count >= AFULL_LVL (1..DEPTH).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  write data from upstream master.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  slave can accept; equals ~full, registered state only, no combinational path from m_ready.
- m_data  out  DATA_W  head-of-FIFO word; forced to 0 when m_valid=0.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  downstream accepts.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_LVL.
- proto_err  out  1  sticky upstream protocol violation.

Behaviour:
- Reset:
  - Clock is clk; reset rst is synchronous, active-high.
  - Taken at the rising edge with rst=1; overrides any push/pop in that cycle.
  - After reset: pointers=0, count=0, m_valid=0, m_data=0, s_ready=1, almost_full=0, proto_err=0.
  - Memory contents are not cleared.
  - Reset mid-stream discards all buffered words; no output handshake completes on the reset edge.
- Push: occurs at an edge where s_valid & s_ready=1; s_data is written at wr_ptr and wr_ptr increments.
- Pop: occurs at an edge where m_valid & m_ready=1; rd_ptr increments.
- Pointers: ADDR_W = $clog2(DEPTH) bits plus one wrap bit. Wrap DEPTH-1 -> 0 toggles the wrap bit.
  - full = address bits equal, wrap bits differ.
  - empty = pointers equal.
- Latency: word pushed at edge N is visible on m_data with m_valid=1 after edge N (first-word fall-through, 1-cycle latency), when the FIFO was empty.
- Ordering: strict FIFO; no reordering, duplication or loss.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, both occur and count is unchanged.
  - When empty: push only, since m_valid=0 and no pop is possible.
  - When full: pop only, since s_ready=0. s_ready rises the cycle after the pop; no same-cycle pass-through.
- count: next = count + push - pop; never exceeds DEPTH and never underflows.
- m_data is a combinational read of mem[rd_ptr] gated by m_valid; held stable while m_valid & ~m_ready.
- proto_err (sticky until rst) is set at edge N when, at edge N-1, s_valid=1 and s_ready=0, and at edge N either:
  - s_valid=0 (valid withdrawn before handshake), or
  - s_data differs from its N-1 value.
  - Detection uses registered copies valid_q/data_q/ready_q, captured every edge.
- Output-side protocol is guaranteed by construction: m_valid is never withdrawn before pop, and m_data is stable while stalled.

Decomposition:
- Package axis_pkg holds the shared definitions:
  - function clog2_f for ADDR_W;
  - localparam DATA_W_DEFAULT=32;
  - typedef for the pointer struct {wrap, addr}.
- Sub-module fifo_ram (DATA_W x DEPTH, one synchronous write port, one asynchronous read port).
  - Pointers, count, flags and proto_err logic stay in axis_slave_fifo.

Test Plan:
- Reset then idle: rst high 2 cycles with s_valid=0 -> s_ready=1, m_valid=0, m_data=0, count=0, proto_err=0.
- Single word: push 32'hA5A5_0001 at edge 5 with m_ready=0 -> m_valid=1 and m_data=32'hA5A5_0001 after edge 5, count=1. Raise m_ready -> pop at edge 7, m_valid=0, m_data=0.
- Fill and stall (DEPTH=4, AFULL_LVL=3), m_ready=0, push 1,2,3,4:
  - almost_full=1 after the 3rd push; s_ready=0 and count=4 after the 4th.
  - Hold s_valid=1 with data 5 -> no push, proto_err stays 0.
  - Then m_ready=1 for one cycle -> pops 1, s_ready=1 the next cycle, word 5 pushed; drain order 2,3,4,5.
- Continuous stream: s_valid=m_ready=1 for 20 cycles, data 0..19 -> one word per cycle after 1-cycle fill, count steady at 1, output sequence 0..19 in order. Pointer wrap is exercised.
- Protocol violation: with FIFO full, drop s_valid while s_ready=0 -> proto_err=1 next edge and stays 1. A separate run changes s_data while stalled -> proto_err=1. rst clears both.
- Reset mid-operation: count=3, assert rst with s_valid=m_ready=1 -> count=0, m_valid=0 after that edge, no word delivered. The next push is the first word out.
